// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC width, instruction-word constants and the
// two-bit branch-predictor counter encoding with its saturating step.
package pipe_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt2_t;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && (cnt != CNT_ST)) begin
            res = cnt + 2'd1;
        end else if (!up && (cnt != CNT_SNT)) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Combinational next value of a CNT_W-bit saturating up/down predictor counter.
module bp_sat_cnt #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             up,
    output logic [CNT_W-1:0] cnt_next
);
    import pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (CNT_W == 2) begin : g_two_bit
            assign cnt_next = sat_step(cnt, up);
        end else begin : g_generic
            always_comb begin
                cnt_next = cnt;
                if (up && (cnt != CNT_MAX)) begin
                    cnt_next = cnt + CNT_W'(1);
                end else if (!up && (cnt != '0)) begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/branch_pred_btb.sv
// Direct-mapped branch target buffer with bimodal direction counters, zero-latency
// lookup for IF, single update port from the resolving stage and saturating stats.
module branch_pred_btb #(
    parameter int ENTRIES   = 16,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 2,
    parameter int PRED_MODE = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_npc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_npc,
    input  logic              inv_all,
    output logic              mispredict,
    output logic [PC_W-1:0]   fix_npc,
    output logic [STAT_W-1:0] stat_upd,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(1) << (CNT_W - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Tag/target/counter are left unreset; valid gates every use of them.
    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    logic [PC_W-1:0]    target_reg [ENTRIES];
    logic [CNT_W-1:0]   cnt_reg    [ENTRIES];

    logic [STAT_W-1:0]  stat_upd_reg;
    logic [STAT_W-1:0]  stat_miss_reg;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               upd_wr;
    logic [CNT_W-1:0]   cnt_step;
    logic [ENTRIES-1:0] entry_we;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

    assign lk_hit  = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    assign pred_taken = (PRED_MODE == 1) && lk_hit && cnt_reg[lk_idx][CNT_W-1];
    assign pred_npc   = pred_taken ? target_reg[lk_idx] : lk_pc + PC_W'(4);

    assign mispredict = upd_valid && (upd_taken ? (!upd_pred_taken || (upd_pred_npc != upd_target))
                                                : upd_pred_taken);
    assign fix_npc    = upd_taken ? upd_target : upd_pc + PC_W'(4);

    // A not-taken miss leaves the table alone; reset and invalidate drop the write.
    assign upd_wr = upd_valid && !rst && !inv_all && (upd_hit || upd_taken);

    bp_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
        .cnt      (cnt_reg[upd_idx]),
        .up       (upd_taken),
        .cnt_next (cnt_step)
    );

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry_we
            assign entry_we[gi] = upd_wr && (upd_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || inv_all) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | entry_we;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_we[i]) begin
                if (!upd_hit) begin
                    tag_reg[i] <= upd_tag;
                end
                if (upd_taken) begin
                    target_reg[i] <= upd_target;
                end
                cnt_reg[i] <= upd_hit ? cnt_step : CNT_INIT;
            end
        end
    end

    // Statistics keep counting through inv_all; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_reg  <= '0;
            stat_miss_reg <= '0;
        end else begin
            if (upd_valid && (stat_upd_reg != STAT_MAX)) begin
                stat_upd_reg <= stat_upd_reg + STAT_W'(1);
            end
            if (mispredict && (stat_miss_reg != STAT_MAX)) begin
                stat_miss_reg <= stat_miss_reg + STAT_W'(1);
            end
        end
    end

    assign stat_upd  = stat_upd_reg;
    assign stat_miss = stat_miss_reg;

endmodule
